// File: rtl/mmio_uart_port.sv
// rtl/mmio_uart_port.sv - memory-mapped UART register port with TX/RX FIFOs
module mmio_uart_port #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int BASE_ADDR = 252,
    parameter int TX_DEPTH  = 4,
    parameter int RX_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              w_en,
    input  logic              r_en,
    output logic              sel,
    output logic [DATA_W-1:0] r_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              irq
);
    localparam int TXA = $clog2(TX_DEPTH);
    localparam int RXA = $clog2(RX_DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [TXA:0] TX_FULL_CNT = (TXA+1)'(TX_DEPTH);
    localparam logic [RXA:0] RX_FULL_CNT = (RXA+1)'(RX_DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} tx_state_t;

    tx_state_t state, state_nxt;
    logic [1:0] hi_cnt;

    logic [DATA_W-1:0] tx_mem [TX_DEPTH];
    logic [TXA-1:0]    tx_wp, tx_rp;
    logic [TXA:0]      tx_cnt;
    logic [DATA_W-1:0] rx_mem [RX_DEPTH];
    logic [RXA-1:0]    rx_wp, rx_rp;
    logic [RXA:0]      rx_cnt;
    logic              rx_ovf, tx_drop;

    logic [1:0] off;
    logic wr_txdata, wr_ctrl, rd_rxdata, ctrl_clear, flush;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic tx_drop_set, rx_ovf_set, tx_idle, fsm_idle;
    logic [DATA_W-1:0] status;

    // BASE_ADDR is 4-aligned, so the window is the upper address bits alone
    assign sel = (addr[ADDR_W-1:2] == BASE[ADDR_W-1:2]);
    assign off = addr[1:0];

    assign wr_txdata  = sel & w_en & (off == 2'd0);
    assign wr_ctrl    = sel & w_en & (off == 2'd3);
    assign rd_rxdata  = sel & r_en & (off == 2'd1);
    assign ctrl_clear = wr_ctrl & w_data[0];
    assign flush      = wr_ctrl & w_data[1];

    assign tx_full  = (tx_cnt == TX_FULL_CNT);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == RX_FULL_CNT);
    assign rx_empty = (rx_cnt == '0);

    assign tx_push     = wr_txdata & ~tx_full & ~flush;
    assign tx_drop_set = wr_txdata & tx_full & ~flush;
    // A pop frees a slot in the same cycle, so a full RX FIFO can still accept
    assign rx_pop      = rd_rxdata & ~rx_empty & ~flush;
    assign rx_push     = rx_valid & (~rx_full | rx_pop) & ~flush;
    assign rx_ovf_set  = rx_valid & rx_full & ~rx_pop & ~flush;

    always_ff @(posedge clock) begin
        if (tx_push)
            tx_mem[tx_wp] <= w_data;
        if (rx_push)
            rx_mem[rx_wp] <= rx_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else if (flush) begin
            tx_wp  <= '0;
            tx_rp  <= '0;
            tx_cnt <= '0;
        end else begin
            if (tx_push)
                tx_wp <= tx_wp + TXA'(1);
            if (tx_pop)
                tx_rp <= tx_rp + TXA'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_cnt <= tx_cnt + (TXA+1)'(1);
                2'b01:   tx_cnt <= tx_cnt - (TXA+1)'(1);
                default: tx_cnt <= tx_cnt;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else if (flush) begin
            rx_wp  <= '0;
            rx_rp  <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push)
                rx_wp <= rx_wp + RXA'(1);
            if (rx_pop)
                rx_rp <= rx_rp + RXA'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_cnt <= rx_cnt + (RXA+1)'(1);
                2'b01:   rx_cnt <= rx_cnt - (RXA+1)'(1);
                default: rx_cnt <= rx_cnt;
            endcase
        end
    end

    // Error set outranks a simultaneous clear so no event is lost
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_ovf  <= 1'b0;
            tx_drop <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (rx_ovf_set)
                rx_ovf <= 1'b1;
            else if (ctrl_clear)
                rx_ovf <= 1'b0;
            if (tx_drop_set)
                tx_drop <= 1'b1;
            else if (ctrl_clear)
                tx_drop <= 1'b0;
            irq <= ~rx_empty | rx_ovf | tx_drop;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            hi_cnt  <= '0;
            tx_data <= '0;
        end else begin
            state <= state_nxt;
            if (state == WAIT_HI)
                hi_cnt <= hi_cnt + 2'd1;
            else
                hi_cnt <= '0;
            if (tx_pop)
                tx_data <= tx_mem[tx_rp];
        end
    end

    // WAIT_HI gives up after four quiet cycles so a silent core cannot hang TX
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!tx_empty && !tx_busy) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT_HI;
            WAIT_HI: begin
                if (tx_busy)
                    state_nxt = WAIT_LO;
                else if (hi_cnt == 2'd3)
                    state_nxt = IDLE;
            end
            WAIT_LO: if (!tx_busy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_start = (state == LAUNCH);
        fsm_idle = (state == IDLE);
        tx_pop   = (state == IDLE) & ~tx_empty & ~tx_busy;
    end

    assign tx_idle = tx_empty & fsm_idle & ~tx_busy;

    always_comb begin
        status    = '0;
        status[0] = tx_full;
        status[1] = ~rx_empty;
        status[2] = rx_ovf;
        status[3] = tx_drop;
        status[4] = tx_idle;
    end

    always_comb begin
        r_data = '0;
        if (sel) begin
            case (off)
                2'd1:    r_data = rx_empty ? '0 : rx_mem[rx_rp];
                2'd2:    r_data = status;
                default: r_data = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_port.sv
// tb/tb_mmio_uart_port.sv - directed bench for mmio_uart_port
module tb_mmio_uart_port;
    logic       clock;
    logic       reset;
    logic [7:0] addr;
    logic [7:0] w_data;
    logic       w_en;
    logic       r_en;
    logic       sel;
    logic [7:0] r_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       irq;

    int n_vec = 0;
    int n_err = 0;

    logic busy_hold = 1'b0;
    int   busy_cnt  = 0;
    int   start_count = 0;

    mmio_uart_port #(
        .ADDR_W(8), .DATA_W(8), .BASE_ADDR(252), .TX_DEPTH(4), .RX_DEPTH(4)
    ) dut (
        .clock(clock), .reset(reset), .addr(addr), .w_data(w_data),
        .w_en(w_en), .r_en(r_en), .sel(sel), .r_data(r_data),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // UART core stand-in: busy for 10 cycles after each launch, or while held
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_start) begin
                busy_cnt = 10;
                start_count++;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            tx_busy = busy_hold || (busy_cnt != 0);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; w_data = d; w_en = 1'b1;
        cyc();
        w_en = 1'b0;
    endtask

    task automatic rd_status(output logic [7:0] d);
        addr = 8'd254; r_en = 1'b0;
        #1;
        d = r_data;
    endtask

    task automatic rd_pop(output logic [7:0] d);
        addr = 8'd253; r_en = 1'b1;
        #1;
        d = r_data;
        cyc();
        r_en = 1'b0;
    endtask

    task automatic inject(input logic [7:0] d);
        rx_data = d; rx_valid = 1'b1;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(output logic ok);
        logic [7:0] s;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            rd_status(s);
            if (s[4]) ok = 1'b1;
            else cyc();
        end
    endtask

    task automatic test_reset();
        logic [7:0] s;
        int starts0;
        starts0 = start_count;
        rd_status(s);
        n_vec++; if (s !== 8'h10) begin n_err++; $display("FAIL reset_status: got %h expected 10", s); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b expected 0", irq); end
        n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        addr = 8'd251; #1;
        n_vec++; if (sel !== 1'b0 || r_data !== 8'h00) begin n_err++; $display("FAIL sel_below: got sel=%b r=%h expected 0/00", sel, r_data); end
        addr = 8'd255; #1;
        n_vec++; if (sel !== 1'b1) begin n_err++; $display("FAIL sel_top: got %b expected 1", sel); end
        repeat (5) cyc();
        n_vec++; if (start_count !== starts0) begin n_err++; $display("FAIL reset_no_start: got %0d starts expected 0", start_count - starts0); end
    endtask

    task automatic test_single_tx();
        logic ok;
        addr = 8'd252; w_data = 8'h41; w_en = 1'b1;
        cyc();
        w_en = 1'b0;
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL lat_n1: got %b expected 0", tx_start); end
        cyc();
        n_vec++; if (tx_start !== 1'b1 || tx_data !== 8'h41) begin n_err++; $display("FAIL lat_n2: got start=%b data=%h expected 1/41", tx_start, tx_data); end
        cyc();
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL lat_n3: got %b expected 0", tx_start); end
        wait_idle(ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL single_idle: got %b expected 1", ok); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s, first;
        logic [7:0] got [4];
        int nst, n, k;
        logic ok;
        nst = 0; first = 8'h00;
        for (int i = 0; i < 6; i++) begin
            addr = 8'd252; w_data = 8'(i + 1); w_en = 1'b1;
            cyc();
            if (tx_start) begin nst++; first = tx_data; end
        end
        w_en = 1'b0;
        busy_hold = 1'b1;
        rd_status(s);
        n_vec++; if (s !== 8'h09) begin n_err++; $display("FAIL b2b_status: got %h expected 09", s); end
        n_vec++; if (nst !== 1 || first !== 8'h01) begin n_err++; $display("FAIL b2b_first: got n=%0d data=%h expected 1/01", nst, first); end
        busy_hold = 1'b0;
        n = 0; k = 0;
        while (n < 4 && k < 300) begin
            cyc();
            if (tx_start) begin got[n] = tx_data; n++; end
            k++;
        end
        n_vec++; if (n !== 4) begin n_err++; $display("FAIL b2b_count: got %0d expected 4", n); end
        for (int i = 0; i < n; i++) begin
            n_vec++; if (got[i] !== 8'(i + 2)) begin n_err++; $display("FAIL b2b_order%0d: got %h expected %h", i, got[i], 8'(i + 2)); end
        end
        wait_idle(ok);
        rd_status(s);
        n_vec++; if (s !== 8'h18) begin n_err++; $display("FAIL b2b_drop_sticky: got %h expected 18", s); end
        wr(8'd255, 8'h01);
        rd_status(s);
        n_vec++; if (s !== 8'h10) begin n_err++; $display("FAIL b2b_clear: got %h expected 10", s); end
    endtask

    task automatic test_rx_overflow();
        logic [7:0] s, d;
        busy_hold = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) inject(8'hA0 + 8'(i));
        cyc();
        rd_status(s);
        n_vec++; if (s !== 8'h06) begin n_err++; $display("FAIL rx_ovf_status: got %h expected 06", s); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL rx_irq: got %b expected 1", irq); end
        for (int i = 0; i < 4; i++) begin
            rd_pop(d);
            n_vec++; if (d !== 8'hA0 + 8'(i)) begin n_err++; $display("FAIL rx_read%0d: got %h expected %h", i, d, 8'hA0 + 8'(i)); end
        end
        rd_pop(d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL rx_empty_read: got %h expected 00", d); end
        rd_status(s);
        n_vec++; if (s !== 8'h04) begin n_err++; $display("FAIL rx_after_drain: got %h expected 04", s); end
        wr(8'd255, 8'h03);
        busy_hold = 1'b0;
        cyc(); cyc();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_cleared: got %b expected 0", irq); end
    endtask

    task automatic test_rx_push_pop_full();
        logic [7:0] s, d;
        for (int i = 0; i < 4; i++) inject(8'hB0 + 8'(i));
        rx_data = 8'hB4; rx_valid = 1'b1;
        addr = 8'd253; r_en = 1'b1;
        #1;
        n_vec++; if (r_data !== 8'hB0) begin n_err++; $display("FAIL pp_head: got %h expected b0", r_data); end
        cyc();
        rx_valid = 1'b0; r_en = 1'b0;
        rd_status(s);
        n_vec++; if (s !== 8'h12) begin n_err++; $display("FAIL pp_status: got %h expected 12", s); end
        for (int i = 0; i < 4; i++) begin
            rd_pop(d);
            n_vec++; if (d !== 8'hB1 + 8'(i)) begin n_err++; $display("FAIL pp_read%0d: got %h expected %h", i, d, 8'hB1 + 8'(i)); end
        end
        rd_pop(d);
        n_vec++; if (d !== 8'h00) begin n_err++; $display("FAIL pp_fifth: got %h expected 00", d); end
    endtask

    task automatic test_reset_mid_transfer();
        logic [7:0] s;
        int starts0, k;
        for (int i = 0; i < 4; i++) wr(8'd252, 8'hC1 + 8'(i));
        busy_hold = 1'b1;
        cyc(); cyc();
        rd_status(s);
        n_vec++; if (s !== 8'h00) begin n_err++; $display("FAIL mid_status: got %h expected 00", s); end
        reset = 1'b1;
        #1;
        n_vec++; if (tx_start !== 1'b0 || irq !== 1'b0 || tx_data !== 8'h00) begin n_err++; $display("FAIL mid_reset_out: got start=%b irq=%b data=%h expected 0/0/00", tx_start, irq, tx_data); end
        cyc();
        reset = 1'b0;
        busy_hold = 1'b0;
        starts0 = start_count;
        k = 0;
        while (tx_busy && k < 40) begin cyc(); k++; end
        n_vec++; if (tx_busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_timeout: got %b expected 0", tx_busy); end
        repeat (6) cyc();
        rd_status(s);
        n_vec++; if (s !== 8'h10) begin n_err++; $display("FAIL mid_after_status: got %h expected 10", s); end
        n_vec++; if (start_count !== starts0 || irq !== 1'b0) begin n_err++; $display("FAIL mid_after_quiet: got starts=%0d irq=%b expected 0/0", start_count - starts0, irq); end
    endtask

    initial begin
        reset = 1'b1; addr = 8'd0; w_data = 8'd0; w_en = 1'b0; r_en = 1'b0;
        rx_data = 8'd0; rx_valid = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        test_reset();
        test_single_tx();
        test_back_to_back();
        test_rx_overflow();
        test_rx_push_pop_full();
        test_reset_mid_transfer();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
